// File: rtl/comp_thresh_load_sched.sv
// comp_thresh_load_sched: round-robin scheduler that hands one of three requesters'
// threshold values to a downstream threshold-load FSM, with timeout and holdoff.
module comp_thresh_load_sched #(
    parameter int TMO_CYC = 63,
    parameter int HOLDOFF = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [2:0]  i_req,
    input  logic [11:0] i_data0,
    input  logic [11:0] i_data1,
    input  logic [11:0] i_data2,
    input  logic        i_clr_err,
    input  logic        i_load_done,
    output logic        o_load_start,
    output logic [11:0] o_dac_data,
    output logic [2:0]  o_grant,
    output logic [2:0]  o_ack,
    output logic        o_busy,
    output logic        o_tmo_err
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;
    // Timeout fires on the edge where the counter would reach TMO_CYC.
    localparam logic [5:0] TMO_LAST  = 6'(TMO_CYC - 1);
    localparam logic [5:0] HOLD_LAST = 6'(HOLDOFF - 1);

    logic [1:0]  r_state;
    logic [1:0]  r_owner;
    logic [1:0]  r_last;
    logic [5:0]  r_cnt;
    logic [2:0]  r_grant;
    logic [2:0]  r_ack;
    logic [11:0] r_dac;
    logic        r_tmo_err;

    logic [1:0]  w_p0;
    logic [1:0]  w_p1;
    logic [1:0]  w_p2;
    logic [1:0]  w_win;
    logic [11:0] w_data;
    logic        w_tmo;

    always_comb begin
        w_p0   = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
        w_p1   = (w_p0 == 2'd2) ? 2'd0 : w_p0 + 2'd1;
        w_p2   = (w_p1 == 2'd2) ? 2'd0 : w_p1 + 2'd1;
        w_win  = i_req[w_p0] ? w_p0 : i_req[w_p1] ? w_p1 : w_p2;
        w_data = (w_win == 2'd0) ? i_data0 : (w_win == 2'd1) ? i_data1 : i_data2;
        w_tmo  = (r_cnt == TMO_LAST);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_owner   <= 2'd0;
            r_last    <= 2'd2;
            r_cnt     <= 6'd0;
            r_grant   <= 3'd0;
            r_ack     <= 3'd0;
            r_dac     <= 12'd0;
            r_tmo_err <= 1'b0;
        end else begin
            r_ack <= 3'd0;
            if (i_clr_err)
                r_tmo_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|i_req) begin
                        r_state <= S_LOAD;
                        r_owner <= w_win;
                        r_grant <= 3'b001 << w_win;
                        r_dac   <= w_data;
                        r_cnt   <= 6'd0;
                    end
                end
                S_LOAD: begin
                    if (i_load_done) begin
                        r_state <= S_WAIT;
                        r_cnt   <= 6'd0;
                    end else if (w_tmo) begin
                        r_state   <= S_HOLD;
                        r_cnt     <= 6'd0;
                        r_tmo_err <= 1'b1;
                        r_last    <= r_owner;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                S_WAIT: begin
                    if (!i_load_done) begin
                        r_state <= S_HOLD;
                        r_cnt   <= 6'd0;
                        r_ack   <= r_grant;
                        r_last  <= r_owner;
                    end else if (w_tmo) begin
                        r_state   <= S_HOLD;
                        r_cnt     <= 6'd0;
                        r_tmo_err <= 1'b1;
                        r_last    <= r_owner;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_state <= S_IDLE;
                        r_grant <= 3'd0;
                        r_cnt   <= 6'd0;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= 3'd0;
                    r_cnt   <= 6'd0;
                end
            endcase
        end
    end

    assign o_load_start = (r_state == S_LOAD);
    assign o_busy       = (r_state != S_IDLE);
    assign o_grant      = r_grant;
    assign o_ack        = r_ack;
    assign o_dac_data   = r_dac;
    assign o_tmo_err    = r_tmo_err;
endmodule

// File: tb/tb_comp_thresh_load_sched.sv
// tb_comp_thresh_load_sched: directed and randomized transactions against a
// transaction-level model of arbitration, load/release phases, holdoff and error flag.
module tb_comp_thresh_load_sched;
    localparam int TMO_CYC = 63;
    localparam int HOLDOFF = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = 3'd0;
    logic [11:0] d0 = 12'd0;
    logic [11:0] d1 = 12'd0;
    logic [11:0] d2 = 12'd0;
    logic        clr = 1'b0;
    logic        done = 1'b0;
    logic        o_load_start;
    logic [11:0] o_dac_data;
    logic [2:0]  o_grant;
    logic [2:0]  o_ack;
    logic        o_busy;
    logic        o_tmo_err;

    int checks = 0;
    int failures = 0;
    int clr_rate = 0;

    logic        m_ls;
    logic        m_busy;
    logic        m_err;
    logic [2:0]  m_gnt;
    logic [2:0]  m_ack;
    logic [11:0] m_dac;
    int          m_last;

    always #5 clk = ~clk;

    comp_thresh_load_sched #(.TMO_CYC(TMO_CYC), .HOLDOFF(HOLDOFF)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req),
        .i_data0(d0), .i_data1(d1), .i_data2(d2),
        .i_clr_err(clr), .i_load_done(done),
        .o_load_start(o_load_start), .o_dac_data(o_dac_data), .o_grant(o_grant),
        .o_ack(o_ack), .o_busy(o_busy), .o_tmo_err(o_tmo_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [2:0] r, input int last);
        for (int k = 1; k <= 3; k++)
            if (r[(last + k) % 3]) return (last + k) % 3;
        return 0;
    endfunction

    task automatic set_idle();
        m_ls = 1'b0; m_gnt = 3'd0; m_ack = 3'd0; m_busy = 1'b0;
    endtask

    // Check the current cycle, drive this cycle's inputs, advance one clock.
    task automatic tick(input logic [2:0] r, input logic dn, input logic fire, input logic force_clr);
        chk("load_start", o_load_start, m_ls);
        chk("grant", o_grant, m_gnt);
        chk("ack", o_ack, m_ack);
        chk("busy", o_busy, m_busy);
        chk("tmo_err", o_tmo_err, m_err);
        chk("dac_data", o_dac_data, m_dac);
        req = r;
        done = dn;
        clr = force_clr | (clr_rate != 0 && $urandom_range(1, clr_rate) == 1);
        @(posedge clk);
        m_err = fire ? 1'b1 : (clr ? 1'b0 : m_err);
        @(negedge clk);
    endtask

    // One arbitration: IDLE sample, LOAD for lat cycles (0 = never done -> timeout),
    // rel cycles of release wait, then the holdoff.
    task automatic episode(input logic [2:0] r, input int lat, input int rel, input logic clr_fire);
        logic [11:0] dv[3];
        logic [2:0]  g;
        int w;
        int n;
        dv[0] = d0; dv[1] = d1; dv[2] = d2;
        w = pick(r, m_last);
        g = 3'b001 << w;
        set_idle();
        tick(r, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        m_dac = dv[w];
        d0 = 12'($urandom); d1 = 12'($urandom); d2 = 12'($urandom);
        n = (lat != 0) ? lat : TMO_CYC;
        for (int i = 0; i < n; i++) begin
            m_ls = 1'b1; m_gnt = g; m_busy = 1'b1; m_ack = 3'd0;
            tick(3'($urandom), lat != 0 && i == lat - 1, lat == 0 && i == n - 1,
                 clr_fire && lat == 0 && i == n - 1);
        end
        m_ls = 1'b0;
        if (lat != 0)
            for (int j = 0; j < rel; j++)
                tick(3'($urandom), j < rel - 1, 1'b0, 1'b0);
        for (int h = 0; h < HOLDOFF; h++) begin
            m_ack = (h == 0 && lat != 0) ? g : 3'd0;
            tick(3'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        m_last = w;
    endtask

    initial begin
        set_idle();
        m_dac = 12'd0; m_err = 1'b0; m_last = 2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // single requester, 18-cycle load
        d0 = 12'hA5C; d1 = 12'($urandom); d2 = 12'($urandom);
        episode(3'b001, 18, 1, 1'b0);
        chk("dac_a5c_held", o_dac_data, 12'hA5C);

        // all requesting: fair rotation
        for (int i = 0; i < 4; i++) episode(3'b111, $urandom_range(1, 10), 1, 1'b0);

        // timeout, sticky error, then clear
        episode(3'b100, 0, 1, 1'b0);
        set_idle();
        tick(3'b000, 1'b0, 1'b0, 1'b0);
        chk("err_sticky", o_tmo_err, 1'b1);
        tick(3'b000, 1'b0, 1'b0, 1'b1);
        tick(3'b000, 1'b0, 1'b0, 1'b0);

        // clear coincident with timeout: timeout wins
        episode(3'b010, 0, 1, 1'b1);
        set_idle();
        tick(3'b000, 1'b0, 1'b0, 1'b0);
        tick(3'b000, 1'b0, 1'b0, 1'b1);

        // reset five cycles into a load
        tick(3'b001, 1'b0, 1'b0, 1'b0);
        m_dac = d0; m_ls = 1'b1; m_gnt = 3'b001; m_busy = 1'b1;
        repeat (5) tick(3'b001, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick(3'b001, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        set_idle();
        m_dac = 12'd0; m_err = 1'b0; m_last = 2;
        episode(3'b010, 5, 2, 1'b0);

        // owner may drop its request mid-load; next owner follows
        episode(3'b001, 3, 1, 1'b0);
        episode(3'b110, 7, 1, 1'b0);
        episode(3'b100, 4, 1, 1'b0);

        clr_rate = 10;
        repeat (25) begin
            episode(3'($urandom_range(1, 7)),
                    ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 25)),
                    $urandom_range(1, 3), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                set_idle();
                tick(3'b000, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            end
        end
        set_idle();
        tick(3'b000, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/comp_thresh_load_sched.md
COMP_THRESH_LOAD_SCHED -- requirements
Module: comp_thresh_load_sched

Interface
REQ-001 Parameter TMO_CYC, default 63: max cycles the scheduler waits in LOAD or WAIT_REL before aborting.
REQ-002 Parameter HOLDOFF, default 4: idle cycles enforced between consecutive loads.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 REQ  input  3  per-requester load request; level, held until the matching ACK bit.
REQ-006 DATA0, DATA1, DATA2  input  12 each  threshold value from requesters 0..2.
REQ-007 CLR_ERR  input  1  clears TMO_ERR.
REQ-008 LOAD_DONE  input  1  SET_DONE from the threshold load FSM.
REQ-009 LOAD_START  output  1  START to the threshold load FSM.
REQ-010 DAC_DATA  output  12  latched threshold value of the granted requester.
REQ-011 GRANT  output  3  one-hot current owner; 0 when none.
REQ-012 ACK  output  3  one-cycle completion pulse to the owner.
REQ-013 BUSY  output  1  high in every state except IDLE.
REQ-014 TMO_ERR  output  1  sticky timeout flag.

Function
REQ-015 The FSM shall have the states IDLE, LOAD, WAIT_REL and HOLD.
REQ-016 In IDLE with REQ!=0, the arbiter shall pick a winner round-robin, searching from (last_owner+1) mod 3 upward; after reset last_owner=2, so requester 0 has first priority.
REQ-017 On the IDLE->LOAD edge, the FSM shall latch GRANT and DAC_DATA=DATAn of the winner; both shall stay stable until the return to IDLE.
REQ-018 LOAD_START shall be 1 exactly while in LOAD, which is the first cycle after REQ is sampled in IDLE (latency 1 cycle).
REQ-019 In LOAD, LOAD_DONE=1 shall cause a transition to WAIT_REL with LOAD_START=0 on the next cycle.
REQ-020 In WAIT_REL, LOAD_DONE=0 shall pulse ACK[owner] for 1 cycle, set last_owner=owner, and enter HOLD.
REQ-021 A 6-bit timeout counter shall clear on entry to LOAD and to WAIT_REL and increment each cycle in those states.
REQ-022 When the counter reaches TMO_CYC, the FSM shall set TMO_ERR, emit no ACK, set last_owner=owner, and go to HOLD (LOAD_START drops).
REQ-023 HOLD shall last exactly HOLDOFF cycles, counted by the same counter, then go to IDLE; GRANT shall clear on entry to IDLE.
REQ-024 REQ[owner] dropping mid-load shall not abort: the load completes and ACK still pulses.
REQ-025 REQ changes outside IDLE shall be ignored until the next arbitration.
REQ-026 CLR_ERR shall clear TMO_ERR; a timeout in the same cycle shall win, leaving TMO_ERR=1.
REQ-027 LOAD_DONE=1 while in IDLE or HOLD shall be ignored.
REQ-028 Unused state encodings shall recover to IDLE with no outputs asserted.
REQ-029 Steady-state arbitration shall be fair: with all REQ held, grants shall cycle 0,1,2,0,...

Reset
REQ-030 RST=1 shall force IDLE, LOAD_START=0, GRANT=0, ACK=0, BUSY=0, DAC_DATA=0, TMO_ERR=0, counter=0 and last_owner=2 at the next rising edge.
REQ-031 RST mid-load shall drop LOAD_START within 1 cycle; the downstream FSM returns to its Idle on its own once START is low.
REQ-032 The first arbitration after RST is released shall grant requester 0 if REQ[0]=1.

Verification
REQ-033 REQ=001, DATA0=0xA5C, model FSM asserts LOAD_DONE 18 cycles after START -> LOAD_START high for 18 cycles, DAC_DATA=0xA5C, one ACK=001 pulse, BUSY clears after HOLDOFF+1.
REQ-034 REQ=111 held continuously -> GRANT sequence 001,010,100,001, each separated by the HOLDOFF gap.
REQ-035 LOAD_DONE never asserted -> LOAD_START drops after 63 cycles, TMO_ERR=1, no ACK; CLR_ERR pulse then clears TMO_ERR.
REQ-036 RST pulsed 5 cycles into LOAD -> next cycle LOAD_START=0, GRANT=0, BUSY=0; a new REQ=010 is then granted normally.
REQ-037 REQ[1] dropped during LOAD with REQ[2] held -> ACK=010 still pulses, followed by GRANT=100.
REQ-038 CLR_ERR asserted in the same cycle a timeout fires -> TMO_ERR remains 1.
